// File: rtl/control_seq.sv
// ID-stage control sequencer: decodes opcodes into the registered ID/EX control
// bundle, inserts bubbles, sequences LD/ST memory waits and guards call depth.
module control_seq #(
  parameter int OPW         = 5,
  parameter int STACK_DEPTH = 8,
  parameter int MEM_WAIT_EN = 1,
  parameter int TIMEOUT     = 15
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [OPW-1:0]                 opcode,
  input  logic                           instr_valid,
  input  logic                           hazard,
  input  logic                           flush,
  input  logic                           mem_ready,
  output logic                           EX_branch,
  output logic                           EX_regwrite,
  output logic                           EX_memtoreg,
  output logic                           EX_memread,
  output logic                           EX_memwrite,
  output logic                           EX_alusrc,
  output logic                           EX_aluop,
  output logic                           EX_regdist,
  output logic                           EX_branchtype,
  output logic                           EX_push,
  output logic                           EX_pop,
  output logic                           EX_ret,
  output logic                           EX_jump,
  output logic                           stall,
  output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
  output logic                           stack_ovf,
  output logic                           stack_unf,
  output logic                           mem_timeout,
  output logic                           illegal_op
);
  localparam int DW = $clog2(STACK_DEPTH+1);
  localparam int CW = $clog2(TIMEOUT+1);

  localparam logic [OPW-1:0] OP_ART  = OPW'(0);
  localparam logic [OPW-1:0] OP_LOG  = OPW'(1);
  localparam logic [OPW-1:0] OP_JMP  = OPW'(2);
  localparam logic [OPW-1:0] OP_BQE  = OPW'(3);
  localparam logic [OPW-1:0] OP_BNE  = OPW'(4);
  localparam logic [OPW-1:0] OP_CALL = OPW'(5);
  localparam logic [OPW-1:0] OP_RET  = OPW'(6);
  localparam logic [OPW-1:0] OP_LD   = OPW'(7);
  localparam logic [OPW-1:0] OP_ST   = OPW'(8);
  localparam logic [OPW-1:0] OP_CRY  = OPW'(9);
  localparam logic [OPW-1:0] OP_IMM  = OPW'(10);

  typedef struct packed {
    logic branch, regwrite, memtoreg, memread, memwrite, alusrc, aluop;
    logic regdist, branchtype, push, pop, ret, jump;
  } ctrl_t;

  typedef enum logic [1:0] {S_DECODE, S_MEMWAIT, S_TRAP} state_t;

  state_t        state_q, state_d;
  ctrl_t         ex_q, ex_d, dec;
  logic [DW-1:0] depth_q, depth_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d, unf_q, unf_d, to_q, to_d, ill_q, ill_d;
  logic          legal, is_call, is_ret, is_mem;

  always_comb begin
    dec   = '0;
    legal = 1'b1;
    case (opcode)
      OP_ART, OP_LOG: begin dec.regdist = 1'b1; dec.regwrite = 1'b1; end
      OP_JMP:         dec.jump = 1'b1;
      OP_BQE:         dec.branch = 1'b1;
      OP_BNE:         begin dec.branch = 1'b1; dec.branchtype = 1'b1; end
      OP_CALL:        begin dec.push = 1'b1; dec.jump = 1'b1; end
      OP_RET:         begin dec.pop = 1'b1; dec.ret = 1'b1; end
      OP_LD:          begin dec.memread = 1'b1; dec.memtoreg = 1'b1;
                            dec.regwrite = 1'b1; dec.alusrc = 1'b1; end
      OP_ST:          begin dec.memwrite = 1'b1; dec.alusrc = 1'b1; end
      OP_CRY:         dec.regwrite = 1'b1;
      OP_IMM:         begin dec.regwrite = 1'b1; dec.alusrc = 1'b1; end
      default:        legal = 1'b0;
    endcase
  end

  assign is_call = (opcode == OP_CALL);
  assign is_ret  = (opcode == OP_RET);
  assign is_mem  = (opcode == OP_LD) || (opcode == OP_ST);

  always_comb begin
    state_d = state_q;
    ex_d    = '0;
    depth_d = depth_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    to_d    = to_q;
    ill_d   = 1'b0;
    case (state_q)
      S_DECODE: begin
        if (flush || hazard || !instr_valid) begin
          // bubble only
        end else if (is_call && depth_q == DW'(STACK_DEPTH)) begin
          ovf_d   = 1'b1;
          state_d = S_TRAP;
        end else if (is_ret && depth_q == '0) begin
          unf_d   = 1'b1;
          state_d = S_TRAP;
        end else if (!legal) begin
          ill_d = 1'b1;
        end else begin
          ex_d = dec;
          if (is_call) depth_d = depth_q + DW'(1);
          if (is_ret)  depth_d = depth_q - DW'(1);
          if (is_mem && MEM_WAIT_EN != 0) begin
            state_d = S_MEMWAIT;
            cnt_d   = '0;
          end
        end
      end
      S_MEMWAIT: begin
        // a flush abandons the wait; the access already issued still completes
        if (flush || mem_ready) begin
          state_d = S_DECODE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_d == CW'(TIMEOUT)) begin
            to_d    = 1'b1;
            state_d = S_TRAP;
          end
        end
      end
      S_TRAP: begin
        if (flush) begin
          state_d = S_DECODE;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          to_d    = 1'b0;
        end
      end
      default: state_d = S_DECODE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_DECODE;
      ex_q    <= '0;
      depth_q <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      to_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ex_q    <= ex_d;
      depth_q <= depth_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      to_q    <= to_d;
      ill_q   <= ill_d;
    end
  end

  assign stall = hazard | (state_q == S_MEMWAIT && !mem_ready) | (state_q == S_TRAP);

  assign EX_branch     = ex_q.branch;
  assign EX_regwrite   = ex_q.regwrite;
  assign EX_memtoreg   = ex_q.memtoreg;
  assign EX_memread    = ex_q.memread;
  assign EX_memwrite   = ex_q.memwrite;
  assign EX_alusrc     = ex_q.alusrc;
  assign EX_aluop      = ex_q.aluop;
  assign EX_regdist    = ex_q.regdist;
  assign EX_branchtype = ex_q.branchtype;
  assign EX_push       = ex_q.push;
  assign EX_pop        = ex_q.pop;
  assign EX_ret        = ex_q.ret;
  assign EX_jump       = ex_q.jump;
  assign depth         = depth_q;
  assign stack_ovf     = ovf_q;
  assign stack_unf     = unf_q;
  assign mem_timeout   = to_q;
  assign illegal_op    = ill_q;
endmodule

// File: tb/tb_control_seq.sv
// Directed bench for control_seq: each scenario task drives vectors and checks
// hand-computed EX bundles, stall, depth and trap flags.
module tb_control_seq;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] opcode;
  logic       instr_valid, hazard, flush, mem_ready;
  logic       EX_branch, EX_regwrite, EX_memtoreg, EX_memread, EX_memwrite, EX_alusrc;
  logic       EX_aluop, EX_regdist, EX_branchtype, EX_push, EX_pop, EX_ret, EX_jump;
  logic       stall, stack_ovf, stack_unf, mem_timeout, illegal_op;
  logic [3:0] depth;
  int         n_cmp = 0;
  int         n_err = 0;

  // bundle bits: branch regwrite memtoreg memread memwrite alusrc aluop regdist branchtype push pop ret jump
  logic [12:0] ex;
  assign ex = {EX_branch, EX_regwrite, EX_memtoreg, EX_memread, EX_memwrite, EX_alusrc,
               EX_aluop, EX_regdist, EX_branchtype, EX_push, EX_pop, EX_ret, EX_jump};

  localparam logic [12:0] B_ART  = 13'h0820;
  localparam logic [12:0] B_LD   = 13'h0E80;
  localparam logic [12:0] B_IMM  = 13'h0880;
  localparam logic [12:0] B_ST   = 13'h0180;
  localparam logic [12:0] B_CALL = 13'h0009;
  localparam logic [12:0] B_RET  = 13'h0006;
  localparam logic [12:0] B_BNE  = 13'h1010;

  localparam logic [4:0] ART = 5'd0, BNE = 5'd4, CALL = 5'd5, RET = 5'd6;
  localparam logic [4:0] LD = 5'd7, ST = 5'd8, IMM = 5'd10;

  control_seq #(.OPW(5), .STACK_DEPTH(8), .MEM_WAIT_EN(1), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .instr_valid(instr_valid),
    .hazard(hazard), .flush(flush), .mem_ready(mem_ready),
    .EX_branch(EX_branch), .EX_regwrite(EX_regwrite), .EX_memtoreg(EX_memtoreg),
    .EX_memread(EX_memread), .EX_memwrite(EX_memwrite), .EX_alusrc(EX_alusrc),
    .EX_aluop(EX_aluop), .EX_regdist(EX_regdist), .EX_branchtype(EX_branchtype),
    .EX_push(EX_push), .EX_pop(EX_pop), .EX_ret(EX_ret), .EX_jump(EX_jump),
    .stall(stall), .depth(depth), .stack_ovf(stack_ovf), .stack_unf(stack_unf),
    .mem_timeout(mem_timeout), .illegal_op(illegal_op));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] op, input logic v, input logic hz, input logic fl,
                       input logic mr);
    opcode = op; instr_valid = v; hazard = hz; flush = fl; mem_ready = mr;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    n_cmp++; if (ex !== 13'h0) begin n_err++; $display("FAIL reset_ex got %h want 0", ex); end
    n_cmp++; if ({depth, stack_ovf, stack_unf, mem_timeout, illegal_op, stall} !== 9'h0) begin
      n_err++; $display("FAIL reset_flags got d=%0d o=%b u=%b t=%b i=%b s=%b want all 0",
                        depth, stack_ovf, stack_unf, mem_timeout, illegal_op, stall); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_art_ld_imm();
    drive(ART, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    n_cmp++; if (ex !== B_ART) begin n_err++; $display("FAIL art_bundle got %h want %h", ex, B_ART); end
    drive(LD, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    n_cmp++; if (ex !== B_LD) begin n_err++; $display("FAIL ld_bundle got %h want %h", ex, B_LD); end
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL ld_wait_stall got %b want 1", stall); end
    drive(IMM, 1'b1, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL ld_ready_stall got %b want 0", stall); end
    tick();
    n_cmp++; if (ex !== 13'h0) begin n_err++; $display("FAIL ld_ready_bubble got %h want 0", ex); end
    drive(IMM, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    n_cmp++; if (ex !== B_IMM) begin n_err++; $display("FAIL imm_bundle got %h want %h", ex, B_IMM); end
  endtask

  task automatic test_mem_timeout();
    drive(ST, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    n_cmp++; if (ex !== B_ST) begin n_err++; $display("FAIL st_bundle got %h want %h", ex, B_ST); end
    drive(ST, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      n_cmp++; if (stall !== 1'b1 || mem_timeout !== 1'b0) begin n_err++;
        $display("FAIL memwait_cycle%0d got stall=%b to=%b want 1 0", i, stall, mem_timeout); end
      tick();
    end
    n_cmp++; if (mem_timeout !== 1'b1 || stall !== 1'b1 || ex !== 13'h0) begin n_err++;
      $display("FAIL timeout_trap got to=%b stall=%b ex=%h want 1 1 0", mem_timeout, stall, ex); end
    drive(ST, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    drive(ST, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (mem_timeout !== 1'b0 || stall !== 1'b0) begin n_err++;
      $display("FAIL timeout_flush got to=%b stall=%b want 0 0", mem_timeout, stall); end
  endtask

  task automatic test_call_overflow();
    for (int i = 1; i <= 8; i++) begin
      drive(CALL, 1'b1, 1'b0, 1'b0, 1'b0); tick();
      n_cmp++; if (ex !== B_CALL || depth !== 4'(i)) begin n_err++;
        $display("FAIL call%0d got ex=%h depth=%0d want %h %0d", i, ex, depth, B_CALL, i); end
    end
    tick();
    n_cmp++; if (ex !== 13'h0 || stack_ovf !== 1'b1 || depth !== 4'd8 || stall !== 1'b1) begin n_err++;
      $display("FAIL call_ovf got ex=%h ovf=%b depth=%0d stall=%b want 0 1 8 1", ex, stack_ovf, depth, stall); end
    tick();
    n_cmp++; if (stall !== 1'b1 || ex !== 13'h0) begin n_err++;
      $display("FAIL ovf_hold got stall=%b ex=%h want 1 0", stall, ex); end
    drive(CALL, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    drive(CALL, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (stack_ovf !== 1'b0 || depth !== 4'd8 || stall !== 1'b0) begin n_err++;
      $display("FAIL ovf_flush got ovf=%b depth=%0d stall=%b want 0 8 0", stack_ovf, depth, stall); end
    for (int i = 7; i >= 0; i--) begin
      drive(RET, 1'b1, 1'b0, 1'b0, 1'b0); tick();
      n_cmp++; if (ex !== B_RET || depth !== 4'(i)) begin n_err++;
        $display("FAIL ret_to%0d got ex=%h depth=%0d want %h %0d", i, ex, depth, B_RET, i); end
    end
  endtask

  task automatic test_ret_underflow();
    drive(RET, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    n_cmp++; if (ex !== 13'h0 || stack_unf !== 1'b1 || stall !== 1'b1 || depth !== 4'd0) begin n_err++;
      $display("FAIL ret_unf got ex=%h unf=%b stall=%b depth=%0d want 0 1 1 0", ex, stack_unf, stall, depth); end
    drive(RET, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    n_cmp++; if (stack_unf !== 1'b0) begin n_err++; $display("FAIL unf_flush got %b want 0", stack_unf); end
    drive(CALL, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    n_cmp++; if (ex !== B_CALL || depth !== 4'd1) begin n_err++;
      $display("FAIL call_after_unf got ex=%h depth=%0d want %h 1", ex, depth, B_CALL); end
    drive(RET, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    n_cmp++; if (ex !== B_RET || depth !== 4'd0) begin n_err++;
      $display("FAIL ret_after_call got ex=%h depth=%0d want %h 0", ex, depth, B_RET); end
  endtask

  task automatic test_hazard_flush();
    for (int i = 0; i < 2; i++) begin
      drive(BNE, 1'b1, 1'b1, 1'b0, 1'b0);
      n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL hazard%0d_stall got %b want 1", i, stall); end
      tick();
      n_cmp++; if (ex !== 13'h0) begin n_err++; $display("FAIL hazard%0d_bubble got %h want 0", i, ex); end
    end
    drive(BNE, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    n_cmp++; if (ex !== B_BNE) begin n_err++; $display("FAIL bne_issue got %h want %h", ex, B_BNE); end
    drive(BNE, 1'b1, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL flush_hazard_stall got %b want 1", stall); end
    tick();
    n_cmp++; if (ex !== 13'h0 || depth !== 4'd0) begin n_err++;
      $display("FAIL flush_hazard_bubble got ex=%h depth=%0d want 0 0", ex, depth); end
  endtask

  task automatic test_illegal();
    drive(5'h1F, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    n_cmp++; if (illegal_op !== 1'b1 || ex !== 13'h0 || stall !== 1'b0) begin n_err++;
      $display("FAIL illegal_pulse got ill=%b ex=%h stall=%b want 1 0 0", illegal_op, ex, stall); end
    drive(5'h1F, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    n_cmp++; if (illegal_op !== 1'b0) begin n_err++; $display("FAIL illegal_clear got %b want 0", illegal_op); end
  endtask

  task automatic test_reset_midwait();
    drive(CALL, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(LD, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(LD, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (ex !== B_LD || stall !== 1'b1 || depth !== 4'd1) begin n_err++;
      $display("FAIL pre_reset got ex=%h stall=%b depth=%0d want %h 1 1", ex, stall, depth, B_LD); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (ex !== 13'h0 || stall !== 1'b0 || depth !== 4'd0 ||
                 {stack_ovf, stack_unf, mem_timeout, illegal_op} !== 4'h0) begin n_err++;
      $display("FAIL async_reset got ex=%h stall=%b depth=%0d flags=%b want all 0", ex, stall, depth,
               {stack_ovf, stack_unf, mem_timeout, illegal_op}); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_art_ld_imm();
    test_mem_timeout();
    test_call_overflow();
    test_ret_underflow();
    test_hazard_flush();
    test_illegal();
    test_reset_midwait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/control_seq.md
Name: control_seq

Overview:
- Pipelined, parametrised control sequencer for the ID stage of the 19-bit CPU.
- Decodes the opcode into the ID control bundle and registers it into ID/EX.
- Inserts bubbles on hazard and flush.
- Sequences multi-cycle LD/ST with a memory-ready wait and a timeout.
- Tracks call-stack depth to trap CALL overflow and RET underflow before they corrupt the stack.

Parameters:
OPW, 5, opcode width; encodings are the project opcode header mnemonics (ART, LOG, JMP, BQE, BNE, CALL, RET, LD, ST, CRY, IMM).
STACK_DEPTH, 8, number of call-stack entries available to CALL.
MEM_WAIT_EN, 1, 1 = LD/ST wait for mem_ready; 0 = single-cycle memory, no wait state.
TIMEOUT, 15, maximum MEMWAIT cycles before mem_timeout trap (>=1).

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  OPW  ID-stage opcode
instr_valid  in  1  opcode is a real instruction this cycle
hazard  in  1  load-use hazard from the hazard unit
flush  in  1  pipeline flush (taken branch/jump or trap recovery)
mem_ready  in  1  data memory has completed the outstanding access
EX_branch, EX_regwrite, EX_memtoreg, EX_memread, EX_memwrite, EX_alusrc, EX_aluop, EX_regdist, EX_branchtype, EX_push, EX_pop, EX_ret, EX_jump  out  1 each  registered control bundle into EX
stall  out  1  freeze PC and IF/ID (combinational)
depth  out  $clog2(STACK_DEPTH+1)  current call depth
stack_ovf  out  1  sticky: CALL attempted at full depth
stack_unf  out  1  sticky: RET attempted at depth 0
mem_timeout  out  1  sticky: MEMWAIT exceeded TIMEOUT
illegal_op  out  1  one-cycle registered pulse: undefined opcode with instr_valid

Behaviour:
- Reset (async, rst_n=0): all EX_* = 0, depth = 0, all flags = 0, wait counter = 0, state = DECODE. Release is synchronous to clk.
- Decode table (all unlisted signals 0):
  - ART/LOG: regdist, regwrite.
  - JMP: jump.
  - BQE: branch, branchtype=0.
  - BNE: branch, branchtype=1.
  - CALL: push, jump.
  - RET: pop, ret.
  - LD: memread, memtoreg, regwrite, alusrc.
  - ST: memwrite, alusrc.
  - CRY: regwrite.
  - IMM: regwrite, alusrc.
- Latency: decoded bundle appears on EX_* one clock after the opcode is presented.
- Bubble: all EX_* = 0 at the next edge.
- States: DECODE, MEMWAIT, TRAP.
- DECODE, per cycle, priority flush > hazard > !instr_valid > stack check > issue:
  - flush: bubble, stay.
  - hazard: bubble, stall=1, opcode must be re-presented.
  - !instr_valid: bubble.
  - CALL with depth==STACK_DEPTH: bubble, set stack_ovf, go TRAP.
  - RET with depth==0: bubble, set stack_unf, go TRAP.
  - Undefined opcode: bubble, pulse illegal_op, stay.
  - Otherwise issue the bundle. CALL does depth+1; RET does depth-1.
  - LD/ST with MEM_WAIT_EN=1: go MEMWAIT, clear wait counter.
- MEMWAIT:
  - EX_* bubble every cycle; stall = !mem_ready.
  - mem_ready=1: go DECODE. Stall drops in that same cycle, so the next opcode is accepted at that edge's following cycle.
  - Else counter+1. Counter reaching TIMEOUT with mem_ready=0: set mem_timeout, go TRAP.
  - flush: go DECODE and abandon the wait; the memory op already issued is not cancelled.
- TRAP:
  - EX_* bubble, stall=1.
  - Only flush exits, to DECODE. Flush clears stack_ovf, stack_unf and mem_timeout in the same edge.
  - depth is preserved.
- Boundaries:
  - stall = hazard | (MEMWAIT & !mem_ready) | TRAP.
  - depth never wraps and is unchanged by flush or hazard.
  - hazard and flush together: flush wins; stall is still asserted that cycle.
  - Async reset mid-MEMWAIT or mid-TRAP returns to reset values immediately.

Test Plan:
- Reset, then ART, LD (mem_ready=1 next cycle), IMM with instr_valid=1 -> EX after 1 cycle: regdist=1,regwrite=1; then LD bundle (memread,memtoreg,regwrite,alusrc=1); 1 bubble with stall=0 at mem_ready; IMM issues next.
- ST with mem_ready held 0, TIMEOUT=15 -> stall=1 for 15 MEMWAIT cycles, mem_timeout=1, TRAP; flush -> DECODE, mem_timeout=0.
- 8 CALLs, then a 9th CALL -> depth counts 1..8, EX_push=EX_jump=1 eight times; 9th gives bubble, stack_ovf=1, stall=1 until flush; depth stays 8.
- RET at depth 0 -> bubble, stack_unf=1, TRAP. Then CALL, RET -> depth 0->1->0, EX_pop=EX_ret=1.
- BNE with hazard=1 for 2 cycles, then hazard=0 -> 2 bubbles with stall=1, then branch=1,branchtype=1. The same with flush=1 and hazard=1 together -> bubble, no issue.
- Undefined opcode 5'h1F with instr_valid=1 -> one-cycle illegal_op pulse, all EX_*=0. rst_n low mid-MEMWAIT -> all outputs 0 immediately.
